// File: rtl/tile_pkg.sv
// Shared types and constants for the Piano Tiles scheduler: game states,
// HID keycodes for the four lane keys and space, and LFSR constants.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  typedef logic [1:0] lane_t;

  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_F     = 8'h09;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_K     = 8'h0E;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int TILE_H = 96;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [3:0] STEP_MAX  = 4'd8;

  function automatic logic is_lane_key(input logic [7:0] key);
    return (key == KEY_D) || (key == KEY_F) || (key == KEY_J) || (key == KEY_K);
  endfunction

  function automatic lane_t key_lane(input logic [7:0] key);
    lane_t lane;
    case (key)
      KEY_D:   lane = 2'd0;
      KEY_F:   lane = 2'd1;
      KEY_J:   lane = 2'd2;
      KEY_K:   lane = 2'd3;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/tile_lfsr.sv
// 8-bit Galois LFSR (taps 8'hB8) choosing spawn lanes; o_lane is taken from
// the value the register moves to when step_en is high.
module tile_lfsr
  import tile_pkg::*;
(
  input  logic  frame_clk,
  input  logic  Reset_n,
  input  logic  step_en,
  output lane_t o_lane
);

  logic [7:0] r_lfsr;
  logic [7:0] w_next;

  always_comb begin
    w_next = r_lfsr >> 1;
    if (r_lfsr[0]) w_next = w_next ^ LFSR_TAPS;
  end

  assign o_lane = w_next[1:0];

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (step_en) begin
      r_lfsr <= w_next;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Piano Tiles game controller: spawns, advances and judges lane tiles and runs
// the IDLE/PLAY/OVER sequence. Define SPEEDUP_EN to raise the fall speed every 16 hits.
module tile_scheduler
  import tile_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SCREEN_H  = 480,
  parameter int SPAWN_GAP = 48,
  parameter int HIT_Y_MIN = 288,
  parameter int BASE_STEP = 2
) (
  input  logic                     frame_clk,
  input  logic                     Reset_n,
  input  logic [7:0]               keycode,
  output logic [NUM_SLOTS-1:0]     tile_valid,
  output logic [2*NUM_SLOTS-1:0]   tile_lane,
  output logic [10*NUM_SLOTS-1:0]  tile_y,
  output logic [15:0]              score,
  output logic [1:0]               game_state,
  output logic                     game_over
);

  localparam int CW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CW-1:0] GAP_LAST   = CW'(SPAWN_GAP - 1);
  localparam logic [10:0]   SCREEN_LIM = 11'(SCREEN_H);
  localparam logic [9:0]    HIT_MIN    = 10'(HIT_Y_MIN);

  state_e               r_state;
  logic                 r_game_over;
  logic [7:0]           r_prev_key;
  logic [NUM_SLOTS-1:0] r_valid;
  lane_t                r_lane [NUM_SLOTS];
  logic [9:0]           r_y    [NUM_SLOTS];
  logic [15:0]          r_score;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           w_step;

`ifdef SPEEDUP_EN
  logic [3:0] r_step;
  assign w_step = r_step;
`else
  assign w_step = 4'(BASE_STEP);
`endif

  logic                 w_press;
  logic                 w_space;
  logic                 w_lane_press;
  lane_t                w_lane;
  logic                 w_tgt_found;
  logic [IW-1:0]        w_tgt_idx;
  logic [9:0]           w_tgt_y;
  logic                 w_hit;
  logic                 w_miss_press;
  logic [10:0]          w_sum [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_keep;
  logic [NUM_SLOTS-1:0] w_retire_v;
  logic                 w_retire;
  logic                 w_free_found;
  logic [IW-1:0]        w_free_idx;
  logic                 w_spawn;
  logic [15:0]          w_score_inc;
  lane_t                w_spawn_lane;

  assign w_press      = (keycode != 8'h00) && (keycode != r_prev_key);
  assign w_space      = w_press && (keycode == KEY_SPACE);
  assign w_lane_press = w_press && is_lane_key(keycode) && (r_state == PLAY);
  assign w_lane       = key_lane(keycode);

  // Target is the lowest tile in the pressed lane; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_tgt_found = 1'b0;
    w_tgt_idx   = '0;
    w_tgt_y     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_valid[i] && (r_lane[i] == w_lane) && (!w_tgt_found || (r_y[i] > w_tgt_y))) begin
        w_tgt_found = 1'b1;
        w_tgt_idx   = IW'(i);
        w_tgt_y     = r_y[i];
      end
    end
  end

  assign w_hit        = w_lane_press && w_tgt_found && (w_tgt_y >= HIT_MIN);
  assign w_miss_press = w_lane_press && !w_hit;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_sum[i]      = {1'b0, r_y[i]} + {7'b0, w_step};
      w_keep[i]     = r_valid[i] && !(w_hit && (w_tgt_idx == IW'(i)));
      w_retire_v[i] = w_keep[i] && (w_sum[i] >= SCREEN_LIM);
    end
  end

  assign w_retire = |w_retire_v;

  // Free-slot search uses pre-update occupancy, so slots vacated this frame wait a frame.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  assign w_spawn     = (r_state == PLAY) && (r_cnt == GAP_LAST) && w_free_found;
  assign w_score_inc = (&r_score) ? r_score : r_score + 16'd1;

  tile_lfsr u_lfsr (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .step_en   (w_spawn),
    .o_lane    (w_spawn_lane)
  );

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_game_over <= 1'b0;
      r_prev_key  <= 8'h00;
      r_valid     <= '0;
      r_score     <= 16'd0;
      r_cnt       <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_lane[i] <= '0;
        r_y[i]    <= '0;
      end
`ifdef SPEEDUP_EN
      r_step      <= 4'(BASE_STEP);
`endif
    end else begin
      r_prev_key <= keycode;
      case (r_state)
        IDLE: begin
          if (w_space) r_state <= PLAY;
        end
        PLAY: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_keep[i] && !w_retire_v[i]) begin
              r_y[i] <= w_sum[i][9:0];
            end else begin
              r_valid[i] <= 1'b0;
              r_lane[i]  <= '0;
              r_y[i]     <= '0;
            end
          end
          r_cnt <= (r_cnt == GAP_LAST) ? '0 : r_cnt + CW'(1);
          if (w_spawn) begin
            r_valid[w_free_idx] <= 1'b1;
            r_lane[w_free_idx]  <= w_spawn_lane;
            r_y[w_free_idx]     <= '0;
          end
          if (w_hit) begin
            r_score <= w_score_inc;
`ifdef SPEEDUP_EN
            if ((w_score_inc[3:0] == 4'd0) && (r_step < STEP_MAX)) r_step <= r_step + 4'd1;
`endif
          end
          if (w_miss_press || w_retire) begin
            r_state     <= OVER;
            r_game_over <= 1'b1;
          end
        end
        OVER: begin
          if (w_space) begin
            r_state     <= IDLE;
            r_game_over <= 1'b0;
            r_valid     <= '0;
            r_score     <= 16'd0;
            r_cnt       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              r_lane[i] <= '0;
              r_y[i]    <= '0;
            end
`ifdef SPEEDUP_EN
            r_step      <= 4'(BASE_STEP);
`endif
          end
        end
        default: begin
          r_state     <= IDLE;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      tile_lane[2*i +: 2] = r_lane[i];
      tile_y[10*i +: 10]  = r_y[i];
    end
  end

  assign tile_valid = r_valid;
  assign score      = r_score;
  assign game_state = r_state;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: a vector table drives the default build,
// and a second instance with SPAWN_GAP=1 covers reset, full slots and hit+retire.
module tb_tile_scheduler;

  localparam logic [7:0] K_F  = 8'h09;
  localparam logic [7:0] K_J  = 8'h0D;
  localparam logic [7:0] K_K  = 8'h0E;
  localparam logic [7:0] K_SP = 8'h2C;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  key;
  logic [7:0]  key6;

  logic [7:0]  valid,  valid6;
  logic [15:0] lane,   lane6;
  logic [79:0] ty,     ty6;
  logic [15:0] score,  score6;
  logic [1:0]  state,  state6;
  logic        over,   over6;

  tile_scheduler dut (
    .frame_clk  (clk),
    .Reset_n    (rst_n),
    .keycode    (key),
    .tile_valid (valid),
    .tile_lane  (lane),
    .tile_y     (ty),
    .score      (score),
    .game_state (state),
    .game_over  (over)
  );

  tile_scheduler #(.SPAWN_GAP(1)) dut6 (
    .frame_clk  (clk),
    .Reset_n    (rst_n),
    .keycode    (key6),
    .tile_valid (valid6),
    .tile_lane  (lane6),
    .tile_y     (ty6),
    .score      (score6),
    .game_state (state6),
    .game_over  (over6)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [7:0]  key;
    int          cycles;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [7:0]  vld;
    int          ys;
    logic [9:0]  y;
    logic [1:0]  ln;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic r, input logic [7:0] k, input int c,
                     input logic [1:0] s, input logic [15:0] sc, input logic [7:0] v,
                     input int ys, input logic [9:0] y, input logic [1:0] ln);
    vec_t t;
    t.name = n; t.rst_n = r; t.key = k; t.cycles = c; t.st = s;
    t.sc = sc; t.vld = v; t.ys = ys; t.y = y; t.ln = ln;
    vq.push_back(t);
  endtask

  // scoreboard compare
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 8'h00;
    key6  = 8'h00;

    //  name        rst key   cyc  state   score valid  slot y    lane
    add("reset",    0, 8'h00,   2, S_IDLE, 0, 8'h00,  0,   0,   0);
    add("idle",     1, 8'h00,   1, S_IDLE, 0, 8'h00, -1,   0,   0);
    add("start",    1, K_SP,    1, S_PLAY, 0, 8'h00, -1,   0,   0);
    add("prespawn", 1, 8'h00,  47, S_PLAY, 0, 8'h00, -1,   0,   0);
    add("spawn",    1, 8'h00,   1, S_PLAY, 0, 8'h01,  0,   0,   2);
    add("step",     1, 8'h00,   1, S_PLAY, 0, 8'h01,  0,   2,   2);
    add("window",   1, 8'h00, 149, S_PLAY, 0, 8'h0F,  0, 300,   2);
    add("hit",      1, K_J,     1, S_PLAY, 1, 8'h0E,  2, 110,   2);
    add("hold",     1, K_J,     5, S_PLAY, 1, 8'h0E, -1,   0,   0);
    add("approach", 1, 8'h00,  40, S_PLAY, 1, 8'h0F,  2, 200,   2);
    add("early",    1, K_J,     1, S_OVER, 1, 8'h0F, -1,   0,   0);
    add("frozen",   1, 8'h00,   3, S_OVER, 1, 8'h0F,  2, 202,   2);
    add("to_idle",  1, K_SP,    1, S_IDLE, 0, 8'h00,  0,   0,   0);
    add("release",  1, 8'h00,   1, S_IDLE, 0, 8'h00, -1,   0,   0);
    add("restart",  1, K_SP,    1, S_PLAY, 0, 8'h00, -1,   0,   0);
    add("empty",    1, K_K,     1, S_OVER, 0, 8'h00, -1,   0,   0);
    add("space2",   1, K_SP,    1, S_IDLE, 0, 8'h00, -1,   0,   0);
    add("reset2",   0, 8'h00,   1, S_IDLE, 0, 8'h00, -1,   0,   0);
    add("release2", 1, 8'h00,   1, S_IDLE, 0, 8'h00, -1,   0,   0);
    add("play3",    1, K_SP,    1, S_PLAY, 0, 8'h00, -1,   0,   0);
    add("cruise",   1, 8'h00, 287, S_PLAY, 0, 8'h1F,  0, 478,   2);
    add("retire",   1, 8'h00,   1, S_OVER, 0, 8'h3E,  5,   0,   0);
    add("clear",    1, K_SP,    1, S_IDLE, 0, 8'h00,  0,   0,   0);

    foreach (vq[n]) begin
      rst_n = vq[n].rst_n;
      key   = vq[n].key;
      repeat (vq[n].cycles) tick();
      exp_q.push_back(vq[n].sc);
      check({vq[n].name, ".state"}, 32'(state), 32'(vq[n].st));
      check({vq[n].name, ".over"},  32'(over),  32'(vq[n].st == S_OVER));
      check({vq[n].name, ".score"}, 32'(score), 32'(exp_q.pop_front()));
      check({vq[n].name, ".valid"}, 32'(valid), 32'(vq[n].vld));
      if (vq[n].ys >= 0) begin
        check({vq[n].name, ".y"},    32'(ty[10*vq[n].ys +: 10]),  32'(vq[n].y));
        check({vq[n].name, ".lane"}, 32'(lane[2*vq[n].ys +: 2]),  32'(vq[n].ln));
      end
    end
    key = 8'h00;

    // Reset in the middle of a game with three live tiles
    key6 = K_SP;
    tick();
    key6 = 8'h00;
    repeat (3) tick();
    check("t1.pre_valid", 32'(valid6), 32'h07);
    rst_n = 1'b0;
    tick();
    check("t1.state", 32'(state6), 32'(S_IDLE));
    check("t1.over",  32'(over6),  0);
    check("t1.valid", 32'(valid6), 0);
    check("t1.lane",  32'(lane6),  0);
    check("t1.y_any", 32'(|ty6),   0);
    check("t1.score", 32'(score6), 0);
    rst_n = 1'b1;
    tick();

    // Spawn every frame until all slots are full, then one skipped spawn
    key6 = K_SP;
    tick();
    key6 = 8'h00;
    repeat (8) tick();
    check("t6.full_valid", 32'(valid6), 32'hFF);
    check("t6.full_lanes", 32'(lane6),  32'hE066);
    tick();
    check("t6.skip_valid", 32'(valid6),        32'hFF);
    check("t6.skip_y0",    32'(ty6[9:0]),      16);
    check("t6.skip_y7",    32'(ty6[79:70]),    2);
    repeat (231) tick();
    check("t6.pre_state",  32'(state6),        32'(S_PLAY));
    check("t6.pre_y0",     32'(ty6[9:0]),      478);
    check("t6.pre_y1",     32'(ty6[19:10]),    476);

    // Hit on slot 1 in the same frame slot 0 retires
    key6 = K_F;
    tick();
    key6 = 8'h00;
    check("t6.hr_state", 32'(state6), 32'(S_OVER));
    check("t6.hr_over",  32'(over6),  1);
    check("t6.hr_score", 32'(score6), 1);
    check("t6.hr_valid", 32'(valid6), 32'hFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
